// File: rtl/sprite_compositor.sv
// Three-stage tank/bullet compositor with frame-latched object state and per-tank hit flash.
// Sprite pixels come from an external ROM addressed by rom_* and return one cycle later.
module sprite_compositor #(
   parameter int          NUM_TANKS    = 2,
   parameter int          BULLETS      = 8,
   parameter int          SPRITE_W     = 32,
   parameter int          SPRITE_H     = 32,
   parameter int          SCALE_X      = 20,
   parameter int          SCALE_Y      = 15,
   parameter int          BALL_R       = 4,
   parameter int          FLASH_FRAMES = 16,
   parameter logic [23:0] BG_RGB       = 24'hE9D8E4,
   parameter logic [23:0] BULLET_RGB   = 24'hFF5500,
   parameter logic [23:0] FLASH_RGB    = 24'hFFFFFF
) (
   input  logic                            CLK,
   input  logic                            Reset,
   input  logic                            frame_start,
   input  logic                            blank,
   input  logic [9:0]                      DrawX,
   input  logic [9:0]                      DrawY,
   input  logic [NUM_TANKS-1:0]            tank_en,
   input  logic [NUM_TANKS*10-1:0]         tank_x,
   input  logic [NUM_TANKS*10-1:0]         tank_y,
   input  logic [NUM_TANKS*3-1:0]          base_dir,
   input  logic [NUM_TANKS*3-1:0]          turret_dir,
   input  logic [NUM_TANKS-1:0]            tank_hit,
   input  logic [NUM_TANKS*BULLETS*32-1:0] bullet_array,
   output logic [9:0]                      rom_x,
   output logic [9:0]                      rom_y,
   output logic [2:0]                      rom_base_sel,
   output logic [2:0]                      rom_tur_sel,
   input  logic [23:0]                     base_rgb,
   input  logic [23:0]                     turret_rgb,
   output logic [7:0]                      Red,
   output logic [7:0]                      Green,
   output logic [7:0]                      Blue,
   output logic                            rgb_valid
);

   localparam int NB    = NUM_TANKS * BULLETS;
   localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
   localparam logic signed [21:0] R_SQ = 22'(BALL_R * BALL_R);

   // 11-bit compare so a sprite near the right/bottom edge never wraps to column/row 0
   function automatic logic in_span(input logic [9:0] d, input logic [9:0] p, input int size);
      logic [10:0] hi;
      hi = {1'b0, p} + 11'(size);
      return ({1'b0, d} >= {1'b0, p}) && ({1'b0, d} < hi);
   endfunction

   function automatic logic [9:0] scale(input logic [9:0] d, input logic [9:0] p, input int k);
      logic [9:0]  loc;
      logic [19:0] prod;
      loc  = d - p;
      prod = loc * 10'(k);
      return prod[9:0];
   endfunction

   function automatic logic disc_hit(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] bx, input logic [9:0] by);
      logic signed [10:0] dx;
      logic signed [10:0] dy;
      logic signed [21:0] sq;
      dx = $signed({1'b0, px}) - $signed({1'b0, bx});
      dy = $signed({1'b0, py}) - $signed({1'b0, by});
      sq = dx * dx + dy * dy;
      return sq <= R_SQ;
   endfunction

   logic [NUM_TANKS-1:0]    en_sh_q, en_sh_d;
   logic [NUM_TANKS*10-1:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d;
   logic [NUM_TANKS*3-1:0]  bdir_sh_q, bdir_sh_d, tdir_sh_q, tdir_sh_d;
   logic [NB-1:0]           bv_sh_q, bv_sh_d;
   logic [NB*10-1:0]        bx_sh_q, bx_sh_d, by_sh_q, by_sh_d;
   logic [CNT_W-1:0]        cnt_q [NUM_TANKS];
   logic [CNT_W-1:0]        cnt_d [NUM_TANKS];
   logic                    unused_bits;

   logic       vld_p1_q, vld_p1_d, hit_p1_q, hit_p1_d, flash_p1_q, flash_p1_d, bul_p1_q, bul_p1_d;
   logic [9:0] rom_x_p1_q, rom_x_p1_d, rom_y_p1_q, rom_y_p1_d;
   logic [2:0] bsel_p1_q, bsel_p1_d, tsel_p1_q, tsel_p1_d;
   logic       vld_p2_q, hit_p2_q, flash_p2_q, bul_p2_q;
   logic       vld_p3_q, vld_p3_d;
   logic [23:0] rgb_q, rgb_d, pix;

   always_comb begin
      en_sh_d     = en_sh_q;
      x_sh_d      = x_sh_q;
      y_sh_d      = y_sh_q;
      bdir_sh_d   = bdir_sh_q;
      tdir_sh_d   = tdir_sh_q;
      bv_sh_d     = bv_sh_q;
      bx_sh_d     = bx_sh_q;
      by_sh_d     = by_sh_q;
      unused_bits = 1'b0;
      if (frame_start) begin
         en_sh_d   = tank_en;
         x_sh_d    = tank_x;
         y_sh_d    = tank_y;
         bdir_sh_d = base_dir;
         tdir_sh_d = turret_dir;
      end
      for (int j = 0; j < NB; j++) begin
         if (frame_start) begin
            bv_sh_d[j]         = bullet_array[32*j];
            bx_sh_d[10*j +: 10] = bullet_array[32*j+9 +: 10];
            by_sh_d[10*j +: 10] = bullet_array[32*j+19 +: 10];
         end
         unused_bits = unused_bits ^ (^bullet_array[32*j+1 +: 8]) ^ (^bullet_array[32*j+29 +: 3]);
      end
      // A hit reloads even on a frame_start cycle
      for (int i = 0; i < NUM_TANKS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tank_hit[i])
            cnt_d[i] = CNT_W'(FLASH_FRAMES);
         else if (frame_start && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - 1'b1;
      end
   end

   // S1: hit tests and ROM address, evaluated against the shadow copies
   always_comb begin
      hit_p1_d   = 1'b0;
      flash_p1_d = 1'b0;
      rom_x_p1_d = '0;
      rom_y_p1_d = '0;
      bsel_p1_d  = '0;
      tsel_p1_d  = '0;
      bul_p1_d   = 1'b0;
      vld_p1_d   = blank;
      for (int i = NUM_TANKS - 1; i >= 0; i--) begin
         if (en_sh_q[i] && in_span(DrawX, x_sh_q[10*i +: 10], SPRITE_W)
                        && in_span(DrawY, y_sh_q[10*i +: 10], SPRITE_H)) begin
            hit_p1_d   = 1'b1;
            flash_p1_d = (cnt_q[i] != '0) && cnt_q[i][1];
            rom_x_p1_d = scale(DrawX, x_sh_q[10*i +: 10], SCALE_X);
            rom_y_p1_d = scale(DrawY, y_sh_q[10*i +: 10], SCALE_Y);
            bsel_p1_d  = bdir_sh_q[3*i +: 3];
            tsel_p1_d  = tdir_sh_q[3*i +: 3];
         end
      end
      for (int j = 0; j < NB; j++)
         if (bv_sh_q[j] && disc_hit(DrawX, DrawY, bx_sh_q[10*j +: 10], by_sh_q[10*j +: 10]))
            bul_p1_d = 1'b1;
   end

   // S3: colour priority using ROM data returned for the S2 address
   always_comb begin
      pix      = (turret_rgb != 24'h0) ? turret_rgb : base_rgb;
      rgb_d    = BG_RGB;
      vld_p3_d = vld_p2_q;
      if (!vld_p2_q)
         rgb_d = 24'h0;
      else if (hit_p2_q) begin
         if (pix != 24'h0)
            rgb_d = flash_p2_q ? FLASH_RGB : pix;
      end else if (bul_p2_q)
         rgb_d = BULLET_RGB;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         en_sh_q    <= '0;
         x_sh_q     <= '0;
         y_sh_q     <= '0;
         bdir_sh_q  <= '0;
         tdir_sh_q  <= '0;
         bv_sh_q    <= '0;
         bx_sh_q    <= '0;
         by_sh_q    <= '0;
         for (int i = 0; i < NUM_TANKS; i++) cnt_q[i] <= '0;
         vld_p1_q   <= 1'b0;
         hit_p1_q   <= 1'b0;
         flash_p1_q <= 1'b0;
         bul_p1_q   <= 1'b0;
         rom_x_p1_q <= '0;
         rom_y_p1_q <= '0;
         bsel_p1_q  <= '0;
         tsel_p1_q  <= '0;
         vld_p2_q   <= 1'b0;
         hit_p2_q   <= 1'b0;
         flash_p2_q <= 1'b0;
         bul_p2_q   <= 1'b0;
         vld_p3_q   <= 1'b0;
         rgb_q      <= '0;
      end else begin
         en_sh_q    <= en_sh_d;
         x_sh_q     <= x_sh_d;
         y_sh_q     <= y_sh_d;
         bdir_sh_q  <= bdir_sh_d;
         tdir_sh_q  <= tdir_sh_d;
         bv_sh_q    <= bv_sh_d;
         bx_sh_q    <= bx_sh_d;
         by_sh_q    <= by_sh_d;
         cnt_q      <= cnt_d;
         vld_p1_q   <= vld_p1_d;
         hit_p1_q   <= hit_p1_d;
         flash_p1_q <= flash_p1_d;
         bul_p1_q   <= bul_p1_d;
         rom_x_p1_q <= rom_x_p1_d;
         rom_y_p1_q <= rom_y_p1_d;
         bsel_p1_q  <= bsel_p1_d;
         tsel_p1_q  <= tsel_p1_d;
         // S2: control follows the ROM access by one stage
         vld_p2_q   <= vld_p1_q;
         hit_p2_q   <= hit_p1_q;
         flash_p2_q <= flash_p1_q;
         bul_p2_q   <= bul_p1_q;
         vld_p3_q   <= vld_p3_d;
         rgb_q      <= rgb_d;
      end
   end

   assign rom_x        = rom_x_p1_q;
   assign rom_y        = rom_y_p1_q;
   assign rom_base_sel = bsel_p1_q;
   assign rom_tur_sel  = tsel_p1_q;
   assign {Red, Green, Blue} = rgb_q;
   assign rgb_valid    = vld_p3_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, scaling, bullets, flash, blanking, reset, edges.
module tb_sprite_compositor;
   localparam int NT = 2;
   localparam int NB = 8;
   localparam logic [23:0] BG = 24'hE9D8E4;
   localparam logic [23:0] BUL = 24'hFF5500;
   localparam logic [23:0] WHT = 24'hFFFFFF;

   logic              CLK = 1'b0;
   logic              Reset, frame_start, blank;
   logic [9:0]        DrawX, DrawY;
   logic [NT-1:0]     tank_en, tank_hit;
   logic [NT*10-1:0]  tank_x, tank_y;
   logic [NT*3-1:0]   base_dir, turret_dir;
   logic [NT*NB*32-1:0] bullet_array;
   logic [9:0]        rom_x, rom_y;
   logic [2:0]        rom_base_sel, rom_tur_sel;
   logic [23:0]       base_rgb, turret_rgb;
   logic [7:0]        Red, Green, Blue;
   logic              rgb_valid;

   int n_chk = 0;
   int n_pass = 0;
   logic [23:0] o_rgb;
   logic        o_vld;
   logic [9:0]  o_rx, o_ry;
   logic [2:0]  o_bs, o_ts;
   logic [15:0] flash_tbl;

   sprite_compositor dut (
      .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .blank(blank),
      .DrawX(DrawX), .DrawY(DrawY), .tank_en(tank_en), .tank_x(tank_x), .tank_y(tank_y),
      .base_dir(base_dir), .turret_dir(turret_dir), .tank_hit(tank_hit),
      .bullet_array(bullet_array), .rom_x(rom_x), .rom_y(rom_y),
      .rom_base_sel(rom_base_sel), .rom_tur_sel(rom_tur_sel),
      .base_rgb(base_rgb), .turret_rgb(turret_rgb),
      .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic fs();
      frame_start = 1'b1;
      @(posedge CLK); #1;
      frame_start = 1'b0;
      tank_hit    = '0;
   endtask

   // One pixel for one cycle, then blanked, so the t+3 sample belongs to this pixel only
   task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b);
      DrawX = x; DrawY = y; blank = b;
      @(posedge CLK); #1;
      o_rx = rom_x; o_ry = rom_y; o_bs = rom_base_sel; o_ts = rom_tur_sel;
      blank = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
      @(posedge CLK);
      @(posedge CLK); #1;
      o_rgb = {Red, Green, Blue};
      o_vld = rgb_valid;
   endtask

   task automatic set_tank(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] bd, input logic [2:0] td);
      tank_x[10*i +: 10]   = x;
      tank_y[10*i +: 10]   = y;
      base_dir[3*i +: 3]   = bd;
      turret_dir[3*i +: 3] = td;
   endtask

   task automatic set_bullet(input int t, input int s, input logic v, input logic [9:0] x, input logic [9:0] y);
      bullet_array[(t*NB+s)*32 +: 32] = {3'b0, y, x, 8'b0, v};
   endtask

   initial begin
      Reset = 1'b1; frame_start = 1'b0; blank = 1'b0; DrawX = '0; DrawY = '0;
      tank_en = '0; tank_hit = '0; tank_x = '0; tank_y = '0; base_dir = '0; turret_dir = '0;
      bullet_array = '0; base_rgb = 24'h123456; turret_rgb = 24'h0;
      flash_tbl = 16'b0011001100110011;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_rgb", {Red, Green, Blue}, 24'h0);
      check("rst_vld", rgb_valid, 1'b0);
      check("rst_romx", rom_x, 10'd0);
      check("rst_romsel", {rom_base_sel, rom_tur_sel}, 6'd0);
      Reset = 1'b0;

      // Before any frame_start nothing is drawn even with inputs enabled
      tank_en = 2'b01; set_tank(0, 10'd100, 10'd100, 3'd2, 3'd5);
      px(10'd100, 10'd100, 1'b1);
      check("pre_fs_bg", o_rgb, BG);

      fs();
      px(10'd100, 10'd100, 1'b1);
      check("t1_rom00", {o_rx, o_ry}, {10'd0, 10'd0});
      check("t1_sel", {o_bs, o_ts}, {3'd2, 3'd5});
      check("t1_rgb", o_rgb, 24'h123456);
      check("t1_vld", o_vld, 1'b1);
      px(10'd131, 10'd131, 1'b1);
      check("t1_rom_far", {o_rx, o_ry}, {10'd620, 10'd465});
      px(10'd132, 10'd100, 1'b1);
      check("t1_outside", o_rgb, BG);

      // Two overlapping tanks: tank0 wins
      tank_en = 2'b11;
      set_tank(0, 10'd200, 10'd200, 3'd3, 3'd1);
      set_tank(1, 10'd200, 10'd200, 3'd6, 3'd7);
      fs();
      px(10'd210, 10'd210, 1'b1);
      check("t2_bsel", o_bs, 3'd3);
      check("t2_tsel", o_ts, 3'd1);
      check("t2_rgb_base", o_rgb, 24'h123456);
      turret_rgb = 24'hABCDEF;
      px(10'd210, 10'd210, 1'b1);
      check("t2_rgb_turret", o_rgb, 24'hABCDEF);
      turret_rgb = 24'h0;

      // Bullet disc, plus a bullet hidden behind a transparent tank pixel
      set_bullet(1, 3, 1'b1, 10'd50, 10'd60);
      set_bullet(0, 1, 1'b1, 10'd205, 10'd205);
      fs();
      px(10'd54, 10'd60, 1'b1); check("t3_54_60", o_rgb, BUL);
      px(10'd53, 10'd62, 1'b1); check("t3_53_62", o_rgb, BUL);
      px(10'd55, 10'd60, 1'b1); check("t3_55_60", o_rgb, BG);
      px(10'd54, 10'd62, 1'b1); check("t3_54_62", o_rgb, BG);
      base_rgb = 24'h0;
      px(10'd205, 10'd205, 1'b1); check("t3_hidden", o_rgb, BG);
      base_rgb = 24'h123456;
      set_bullet(1, 3, 1'b0, 10'd50, 10'd60);
      set_bullet(0, 1, 1'b0, 10'd205, 10'd205);
      px(10'd54, 10'd60, 1'b1); check("t3_shadow_hold", o_rgb, BUL);
      fs();
      px(10'd54, 10'd60, 1'b1); check("t3_cleared", o_rgb, BG);

      // Hit flash on tank1, load coinciding with frame_start
      tank_en = 2'b10;
      set_tank(1, 10'd300, 10'd300, 3'd0, 3'd0);
      tank_hit = 2'b10;
      fs();
      px(10'd300, 10'd300, 1'b1); check("t4_cnt16", o_rgb, 24'h123456);
      for (int k = 1; k <= 16; k++) begin
         fs();
         px(10'd305, 10'd305, 1'b1);
         check($sformatf("t4_frame%0d", k), o_rgb, flash_tbl[k-1] ? WHT : 24'h123456);
         if (k == 1) begin
            base_rgb = 24'h0;
            px(10'd305, 10'd305, 1'b1);
            check("t4_flash_transp", o_rgb, BG);
            base_rgb = 24'h123456;
         end
      end
      fs();
      px(10'd305, 10'd305, 1'b1); check("t4_after", o_rgb, 24'h123456);

      // Blanking and mid-line reset
      tank_en = 2'b01;
      set_tank(0, 10'd100, 10'd100, 3'd0, 3'd0);
      fs();
      px(10'd110, 10'd110, 1'b0);
      check("t5_blank_rgb", o_rgb, 24'h0);
      check("t5_blank_vld", o_vld, 1'b0);
      DrawX = 10'd110; DrawY = 10'd110; blank = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check("t5_stream", {Red, Green, Blue}, 24'h123456);
      Reset = 1'b1;
      @(posedge CLK); #1;
      check("t5_rst_rgb", {Red, Green, Blue}, 24'h0);
      check("t5_rst_vld", rgb_valid, 1'b0);
      Reset = 1'b0;
      px(10'd110, 10'd110, 1'b1);
      check("t5_hidden", o_rgb, BG);
      check("t5_hidden_vld", o_vld, 1'b1);
      fs();
      px(10'd110, 10'd110, 1'b1);
      check("t5_back", o_rgb, 24'h123456);

      // Screen-edge tank and near-origin bullet
      set_tank(0, 10'd630, 10'd470, 3'd0, 3'd0);
      set_bullet(0, 0, 1'b1, 10'd2, 10'd2);
      fs();
      px(10'd629, 10'd470, 1'b1); check("t6_left", o_rgb, BG);
      px(10'd630, 10'd469, 1'b1); check("t6_above", o_rgb, BG);
      px(10'd630, 10'd470, 1'b1); check("t6_corner", o_rgb, 24'h123456);
      px(10'd639, 10'd479, 1'b1); check("t6_rom_edge", {o_rx, o_ry}, {10'd180, 10'd135});
      px(10'd0, 10'd0, 1'b1);     check("t6_bul_origin", o_rgb, BUL);
      px(10'd1020, 10'd2, 1'b1);  check("t6_no_alias", o_rgb, BG);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
